uart_prog_loader: RTL and testbench

Parametrised UART program loader: receives a framed image over a serial line, assembles little-endian words and writes them into one of several target memories through the `upg_*` write port that the instruction and data memories already accept. It generalises the fixed 15-bit/32-bit/two-memory programmer with four additions:

- configurable word width, address width and target count;
- a length header and a checksum;
- an idle timeout;
- an ACK/NAK reply on TX.

It sits beside the CPU top. While `upg_done_o` is low the CPU is held in reset.

---
 rtl/upg_pkg.sv | 28 ++
 rtl/upg_uart_rx.sv | 112 +++++++++++
 rtl/uart_prog_loader.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upg_pkg.sv
// Shared definitions for the UART program loader: loader states, receiver
// states, reply bytes and the running-checksum helper.
package upg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_ACK  = 3'd5,
    ST_NAK  = 3'd6,
    ST_DONE = 3'd7
  } upg_state_e;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [7:0] UPG_ACK = 8'h06;
  localparam logic [7:0] UPG_NAK = 8'h15;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/upg_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampler with start-bit
// glitch rejection, one-cycle byte-valid and framing-error strobes.
module upg_uart_rx
  import upg_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       valid_o,
  output logic [7:0] byte_o,
  output logic       ferr_o
);

  localparam int CNT_W = $clog2(DIV);

  logic             sync1_q, sync2_q, prev_q;
  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             fall_s, tick_s, half_s, stop_s;

  assign fall_s  = prev_q & ~sync2_q;
  assign tick_s  = (cnt_q == CNT_W'(DIV - 1));
  assign half_s  = (cnt_q == CNT_W'(DIV / 2 - 1));
  assign stop_s  = (st_q == RX_STOP) && tick_s;
  // Strobes fire during the stop-sample cycle so the loader can register them directly.
  assign valid_o = stop_s & sync2_q;
  assign ferr_o  = stop_s & ~sync2_q;
  assign byte_o  = sh_q;

  // Synchroniser and edge-history flops; the line idles high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Receiver sequencing: start check at half a bit, then one sample per bit.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q + CNT_W'(1);
    bit_d = bit_q;
    sh_d  = sh_q;
    case (st_q)
      RX_IDLE: begin
        cnt_d = CNT_W'(0);
        if (fall_s) st_d = RX_START;
        else        st_d = RX_IDLE;
      end
      RX_START: begin
        if (half_s) begin
          cnt_d = CNT_W'(0);
          bit_d = 3'd0;
          if (sync2_q) st_d = RX_IDLE;
          else         st_d = RX_DATA;
        end else begin
          st_d = RX_START;
        end
      end
      RX_DATA: begin
        if (tick_s) begin
          cnt_d = CNT_W'(0);
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
          else               st_d = RX_DATA;
        end else begin
          st_d = RX_DATA;
        end
      end
      RX_STOP: begin
        // A new start edge coinciding with the stop sample is taken immediately.
        if (tick_s) begin
          cnt_d = CNT_W'(0);
          if (fall_s) st_d = RX_START;
          else        st_d = RX_IDLE;
        end else begin
          st_d = RX_STOP;
        end
      end
      default: begin
        st_d  = RX_IDLE;
        cnt_d = CNT_W'(0);
      end
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q  <= RX_IDLE;
      cnt_q <= CNT_W'(0);
      bit_q <= 3'd0;
      sh_q  <= 8'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: parses TGT/LEN/data/CSUM frames, writes little-endian
// words to the selected memory and answers with ACK or NAK on TX.
module uart_prog_loader
  import upg_pkg::*;
#(
  parameter int  DIV       = 868,
  parameter int  DATA_W    = 32,
  parameter int  ADDR_W    = 14,
  parameter int  N_TARGETS = 2,
  parameter int  TIMEOUT   = 1_000_000,
  localparam int SEL_W     = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              upg_rx_i,
  output logic              upg_tx_o,
  output logic              upg_wen_o,
  output logic [SEL_W-1:0]  upg_sel_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [DATA_W-1:0] upg_dat_o,
  output logic              upg_busy_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam int          BPW       = DATA_W / 8;
  localparam int          BI_W      = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int          CNT_W     = $clog2(DIV);
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  logic        rx_valid_s, rx_err_s;
  logic [7:0]  rx_byte_s;

  upg_state_e        state_q, state_d;
  logic [7:0]        tgt_q, tgt_d, csum_q, csum_d;
  logic [15:0]       len_q, len_d, wcnt_q, wcnt_d, len_full_s;
  logic [DATA_W-1:0] word_q, word_d, word_nx_s, dat_q, dat_d;
  logic [BI_W-1:0]   bidx_q, bidx_d;
  logic [31:0]       to_q, to_d;
  logic              wen_q, wen_d, err_q, err_d, done_q, done_d, busy_q, busy_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              tx_q, tx_d, tx_run_q, tx_run_d;
  logic [8:0]        tx_sh_q, tx_sh_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic              waiting_s, abort_s, hdr_bad_s;

  upg_uart_rx #(.DIV(DIV)) u_rx (
    .clk_i   (upg_clk_i),
    .rst_i   (upg_rst_i),
    .rx_i    (upg_rx_i),
    .valid_o (rx_valid_s),
    .byte_o  (rx_byte_s),
    .ferr_o  (rx_err_s)
  );

  assign len_full_s = {rx_byte_s, len_q[7:0]};
  assign hdr_bad_s  = ({24'd0, tgt_q} >= 32'(N_TARGETS)) || ({17'd0, len_full_s} > MAX_WORDS);
  assign word_nx_s  = (word_q >> 8) | (DATA_W'(rx_byte_s) << (DATA_W - 8));
  assign waiting_s  = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign abort_s    = waiting_s && (rx_err_s || (to_q >= 32'(TIMEOUT)));

  // Loader FSM, word assembly and reply transmitter.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    csum_d   = csum_q;
    len_d    = len_q;
    wcnt_d   = wcnt_q;
    word_d   = word_q;
    bidx_d   = bidx_q;
    wen_d    = 1'b0;
    err_d    = 1'b0;
    sel_d    = sel_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    done_d   = done_q;
    tx_d     = tx_q;
    tx_run_d = tx_run_q;
    tx_sh_d  = tx_sh_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    if (waiting_s && !rx_valid_s) to_d = to_q + 32'd1;
    else                          to_d = 32'd0;

    if (abort_s) begin
      state_d = ST_NAK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid_s) begin
            tgt_d   = rx_byte_s;
            csum_d  = rx_byte_s;
            len_d   = 16'd0;
            wcnt_d  = 16'd0;
            bidx_d  = BI_W'(0);
            state_d = ST_LEN0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LEN0: begin
          if (rx_valid_s) begin
            len_d   = {8'd0, rx_byte_s};
            csum_d  = csum_add(csum_q, rx_byte_s);
            state_d = ST_LEN1;
          end else begin
            state_d = ST_LEN0;
          end
        end
        ST_LEN1: begin
          if (rx_valid_s) begin
            len_d  = len_full_s;
            csum_d = csum_add(csum_q, rx_byte_s);
            if (hdr_bad_s)                 state_d = ST_NAK;
            else if (len_full_s == 16'd0)  state_d = ST_CSUM;
            else                           state_d = ST_DATA;
          end else begin
            state_d = ST_LEN1;
          end
        end
        ST_DATA: begin
          if (rx_valid_s) begin
            csum_d = csum_add(csum_q, rx_byte_s);
            word_d = word_nx_s;
            if (bidx_q == BI_W'(BPW - 1)) begin
              bidx_d = BI_W'(0);
              wen_d  = 1'b1;
              sel_d  = SEL_W'(tgt_q);
              adr_d  = ADDR_W'(wcnt_q);
              dat_d  = word_nx_s;
              wcnt_d = wcnt_q + 16'd1;
              if (wcnt_q == len_q - 16'd1) state_d = ST_CSUM;
              else                         state_d = ST_DATA;
            end else begin
              bidx_d = bidx_q + BI_W'(1);
            end
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_CSUM: begin
          if (rx_valid_s) begin
            if (rx_byte_s == csum_q) state_d = ST_ACK;
            else                     state_d = ST_NAK;
          end else begin
            state_d = ST_CSUM;
          end
        end
        ST_ACK, ST_NAK: begin
          // The state is left exactly when the stop bit has been on the line for DIV cycles.
          if (!tx_run_q) begin
            tx_run_d = 1'b1;
            tx_d     = 1'b0;
            tx_sh_d  = {1'b1, (state_q == ST_ACK) ? UPG_ACK : UPG_NAK};
            tx_cnt_d = CNT_W'(0);
            tx_bit_d = 4'd0;
          end else if (tx_cnt_q == CNT_W'(DIV - 1)) begin
            tx_cnt_d = CNT_W'(0);
            if (tx_bit_q == 4'd9) begin
              tx_run_d = 1'b0;
              tx_d     = 1'b1;
              if (state_q == ST_ACK) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
              end
            end else begin
              tx_bit_d = tx_bit_q + 4'd1;
              tx_d     = tx_sh_q[0];
              tx_sh_d  = {1'b1, tx_sh_q[8:1]};
            end
          end else begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // Loader and output registers.
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      state_q  <= ST_IDLE;
      tgt_q    <= 8'd0;
      csum_q   <= 8'd0;
      len_q    <= 16'd0;
      wcnt_q   <= 16'd0;
      word_q   <= DATA_W'(0);
      bidx_q   <= BI_W'(0);
      to_q     <= 32'd0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      sel_q    <= SEL_W'(0);
      adr_q    <= ADDR_W'(0);
      dat_q    <= DATA_W'(0);
      tx_q     <= 1'b1;
      tx_run_q <= 1'b0;
      tx_sh_q  <= 9'h1FF;
      tx_cnt_q <= CNT_W'(0);
      tx_bit_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      csum_q   <= csum_d;
      len_q    <= len_d;
      wcnt_q   <= wcnt_d;
      word_q   <= word_d;
      bidx_q   <= bidx_d;
      to_q     <= to_d;
      wen_q    <= wen_d;
      err_q    <= err_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      tx_q     <= tx_d;
      tx_run_q <= tx_run_d;
      tx_sh_q  <= tx_sh_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
    end
  end

  assign upg_tx_o   = tx_q;
  assign upg_wen_o  = wen_q;
  assign upg_sel_o  = sel_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_busy_o = busy_q;
  assign upg_done_o = done_q;
  assign upg_err_o  = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench: frames are serialised onto RX, a frame-level model
// predicts writes and the reply byte, and TX is decoded back into bytes.
module tb_uart_prog_loader;

  localparam int DIV     = 8;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 14;
  localparam int NT      = 2;
  localparam int TIMEOUT = 400;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx  = 1'b1;
  logic              tx, wen, busy, done, err;
  logic [0:0]        sel;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat;

  typedef struct packed {
    logic [0:0]        sel;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
  } wr_t;

  wr_t        wr_q[$];
  wr_t        exp_wr[$];
  logic [7:0] frame_q[$];
  logic [7:0] exp_reply;
  int         checks = 0;
  int         errors = 0;
  int         err_cnt = 0;
  int         tx_low_cycles = 0;
  int         last_wait = 0;

  always #5 clk = ~clk;

  uart_prog_loader #(
    .DIV(DIV), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_TARGETS(NT), .TIMEOUT(TIMEOUT)
  ) dut (
    .upg_clk_i  (clk),
    .upg_rst_i  (rst),
    .upg_rx_i   (rx),
    .upg_tx_o   (tx),
    .upg_wen_o  (wen),
    .upg_sel_o  (sel),
    .upg_adr_o  (adr),
    .upg_dat_o  (dat),
    .upg_busy_o (busy),
    .upg_done_o (done),
    .upg_err_o  (err)
  );

  always @(negedge clk) begin
    if (wen === 1'b1) wr_q.push_back({sel, adr, dat});
    if (err === 1'b1) err_cnt++;
    if (tx === 1'b0) tx_low_cycles++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_bit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic add_csum(input logic [7:0] delta);
    logic [7:0] s;
    s = delta;
    foreach (frame_q[i]) s = s + frame_q[i];
    frame_q.push_back(s);
  endtask

  // Frame-level reference: header rules, little-endian words, modulo-256 checksum.
  task automatic model_expect();
    int         tgt, n;
    logic [7:0] s;
    wr_t        e;
    exp_wr.delete();
    tgt = int'(frame_q[0]);
    n   = int'({frame_q[2], frame_q[1]});
    if (tgt >= NT || n > (1 << ADDR_W)) begin
      exp_reply = 8'h15;
    end else begin
      for (int w = 0; w < n; w++) begin
        e.sel = tgt[0];
        e.adr = ADDR_W'(w);
        e.dat = {frame_q[6+4*w], frame_q[5+4*w], frame_q[4+4*w], frame_q[3+4*w]};
        exp_wr.push_back(e);
      end
      s = 8'd0;
      for (int i = 0; i < frame_q.size() - 1; i++) s = s + frame_q[i];
      exp_reply = (s == frame_q[frame_q.size()-1]) ? 8'h06 : 8'h15;
    end
  endtask

  task automatic wait_reply(input logic [7:0] expb, input string tag);
    logic [7:0] got;
    logic       stop;
    bit         seen;
    last_wait = 0;
    seen = 1'b0;
    while (!seen && last_wait < TIMEOUT + 40 * DIV) begin
      @(negedge clk);
      last_wait++;
      if (tx === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_reply_start: tx stayed idle for %0d cycles, expected byte %h", tag, last_wait, expb);
    end else begin
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        got[i] = tx;
      end
      repeat (DIV) @(negedge clk);
      stop = tx;
      checks++;
      if (got !== expb || stop !== 1'b1) begin
        errors++;
        $display("FAIL %s_reply_byte: got %h stop %b, expected %h stop 1", tag, got, stop, expb);
      end
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic check_writes(input string tag);
    checks++;
    if (wr_q.size() !== exp_wr.size()) begin
      errors++;
      $display("FAIL %s_write_count: got %0d, expected %0d", tag, wr_q.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        checks++;
        if (wr_q[i] !== exp_wr[i]) begin
          errors++;
          $display("FAIL %s_write%0d: got sel=%0d adr=%0d dat=%h, expected sel=%0d adr=%0d dat=%h",
                   tag, i, wr_q[i].sel, wr_q[i].adr, wr_q[i].dat, exp_wr[i].sel, exp_wr[i].adr, exp_wr[i].dat);
        end
      end
    end
  endtask

  task automatic run_frame(input string tag);
    int e0;
    model_expect();
    wr_q.delete();
    e0 = err_cnt;
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
    wait_reply(exp_reply, tag);
    check_writes(tag);
    checks++;
    if (done !== (exp_reply == 8'h06)) begin
      errors++;
      $display("FAIL %s_done: got %b, expected %b", tag, done, exp_reply == 8'h06);
    end
    checks++;
    if ((err_cnt - e0) != ((exp_reply == 8'h15) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s_err_pulses: got %0d, expected %0d", tag, err_cnt - e0, (exp_reply == 8'h15) ? 1 : 0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: got %b, expected 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tx, wen, done, err, busy, sel, adr, dat} !== {1'b1, 5'd0, 14'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got tx=%b wen=%b done=%b err=%b busy=%b sel=%0d adr=%0d dat=%h, expected tx=1 rest 0",
               tx, wen, done, err, busy, sel, adr, dat);
    end
  endtask

  task automatic test_load_ram();
    do_reset();
    frame_q = '{8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_csum(8'd0);
    run_frame("load_ram");
  endtask

  task automatic test_done_ignore();
    int t0;
    wr_q.delete();
    t0 = tx_low_cycles;
    frame_q = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    add_csum(8'd0);
    foreach (frame_q[i]) send_byte(frame_q[i], 1'b1);
    repeat (12 * DIV) @(negedge clk);
    checks++;
    if (wr_q.size() != 0 || done !== 1'b1 || busy !== 1'b0 || tx_low_cycles != t0) begin
      errors++;
      $display("FAIL done_ignore: got writes=%0d done=%b busy=%b tx_low=%0d, expected 0 1 0 0",
               wr_q.size(), done, busy, tx_low_cycles - t0);
    end
  endtask

  task automatic test_bad_csum();
    do_reset();
    frame_q = '{8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_csum(8'd1);
    run_frame("bad_csum");
    frame_q = '{8'h00, 8'h01, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    add_csum(8'd0);
    run_frame("after_nak");
  endtask

  task automatic test_zero_len();
    do_reset();
    frame_q = '{8'h00, 8'h00, 8'h00};
    add_csum(8'd0);
    run_frame("zero_len");
  endtask

  task automatic test_bad_header();
    do_reset();
    frame_q = '{8'h02, 8'h01, 8'h00};
    run_frame("bad_tgt");
    checks++;
    if (last_wait > 2) begin
      errors++;
      $display("FAIL bad_tgt_latency: reply began %0d cycles after LEN_H, expected at most 2", last_wait);
    end
    frame_q = '{8'h01, 8'h01, 8'h40};
    run_frame("bad_len");
  endtask

  task automatic test_stop_fault();
    int e0;
    do_reset();
    wr_q.delete();
    e0 = err_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b0);
    wait_reply(8'h15, "stop_fault");
    checks++;
    if (wr_q.size() != 0 || done !== 1'b0 || (err_cnt - e0) != 1) begin
      errors++;
      $display("FAIL stop_fault_after: got writes=%0d done=%b err=%0d, expected 0 0 1", wr_q.size(), done, err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    int e0;
    do_reset();
    wr_q.delete();
    e0 = err_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_reply(8'h15, "timeout");
    checks++;
    if (last_wait < TIMEOUT - DIV || last_wait > TIMEOUT + 2 * DIV) begin
      errors++;
      $display("FAIL timeout_latency: reply after %0d idle cycles, expected about %0d", last_wait, TIMEOUT);
    end
    checks++;
    if (wr_q.size() != 0 || done !== 1'b0 || (err_cnt - e0) != 1) begin
      errors++;
      $display("FAIL timeout_after: got writes=%0d done=%b err=%0d, expected 0 0 1", wr_q.size(), done, err_cnt - e0);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: got %b, expected 0", busy);
    end
    frame_q = '{8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 4; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    add_csum(8'd0);
    run_frame("after_glitch");
  endtask

  task automatic test_random();
    int tgt, n;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      tgt = $urandom_range(0, 2);
      n   = $urandom_range(0, 3);
      frame_q = '{};
      frame_q.push_back(8'(tgt));
      frame_q.push_back(8'(n));
      frame_q.push_back(8'd0);
      if (tgt < NT) begin
        for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
        add_csum(($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0);
      end
      run_frame($sformatf("random%0d", it));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    frame_q = '{8'h00, 8'h03, 8'h00};
    for (int i = 0; i < 12; i++) frame_q.push_back(8'($urandom_range(0, 255)));
    add_csum(8'd0);
    run_frame("back_to_back");
  endtask

  task automatic test_reset_midword();
    do_reset();
    wr_q.delete();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h81 + 8'(i), 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b1);
    checks++;
    if (wr_q.size() != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midword_pre: got writes=%0d busy=%b, expected 1 1", wr_q.size(), busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({tx, wen, done, err, busy, sel, adr, dat} !== {1'b1, 5'd0, 14'd0, 32'd0}) begin
      errors++;
      $display("FAIL midword_reset: got tx=%b wen=%b done=%b err=%b busy=%b sel=%0d adr=%0d dat=%h, expected tx=1 rest 0",
               tx, wen, done, err, busy, sel, adr, dat);
    end
    rst = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    checks++;
    if (wr_q.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midword_post: got writes=%0d busy=%b, expected 1 0", wr_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_load_ram();
    test_done_ignore();
    test_bad_csum();
    test_zero_len();
    test_bad_header();
    test_stop_fault();
    test_timeout();
    test_glitch();
    test_random();
    test_back_to_back();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
